// File: rtl/semaforo_ctrl.sv
// ---------------------------------------------------------------------------
// semaforo_ctrl
// Controller for a two-approach intersection: NS is the main road, EW is the
// side road. A tick prescaler drives a six-phase cycle:
//   NS_GREEN -> NS_YELLOW -> ALLRED_A -> EW_GREEN -> EW_YELLOW -> ALLRED_B
// A pedestrian request is latched until it is served. Once the minimum green
// time has elapsed, a pending request cuts NS green short. ped_ack pulses for
// one cycle after the NS green that served the request.
// While maintenance mode is on, the lights follow the manual inputs and all
// timing state is frozen. If both manual greens are on, both approaches are
// forced to red.
//
// Optional feature (macro SEMAFORO_FLASH_EN): adds a 'night' input. While it
// is high, both approaches flash yellow and the phase cycle is parked in
// ALLRED_B.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   maint      in   maintenance override enable
//   man_ns     in   [2:0] manual NS lights {red,yellow,green}
//   man_ew     in   [2:0] manual EW lights {red,yellow,green}
//   ped_req    in   pedestrian request, sampled every cycle
//   night      in   flashing night mode (only with SEMAFORO_FLASH_EN)
//   ped_ack    out  one-cycle pulse when a pending request is served
//   ns_lights  out  [2:0] NS lights {red,yellow,green}
//   ew_lights  out  [2:0] EW lights {red,yellow,green}
//   phase      out  [2:0] current phase encoding
// ---------------------------------------------------------------------------
module semaforo_ctrl #(
  parameter int CLK_DIV         = 4,
  parameter int GREEN_TICKS     = 6,
  parameter int MIN_GREEN_TICKS = 2,
  parameter int YELLOW_TICKS    = 2,
  parameter int ALLRED_TICKS    = 1,
  parameter int CNT_W           = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       maint,
  input  logic [2:0] man_ns,
  input  logic [2:0] man_ew,
  input  logic       ped_req,
`ifdef SEMAFORO_FLASH_EN
  input  logic       night,
`endif
  output logic       ped_ack,
  output logic [2:0] ns_lights,
  output logic [2:0] ew_lights,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALLRED_A  = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALLRED_B  = 3'd5
  } phase_e;

  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;

  // Each duration is stored as its last timer value so it can be compared
  // with the timer directly.
  localparam logic [CNT_W-1:0] PRESC_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] MIN_LAST    = CNT_W'(MIN_GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_TICKS - 1);

  phase_e           phase_q,    phase_d;
  logic [CNT_W-1:0] presc_q,    presc_d;
  logic [CNT_W-1:0] timer_q,    timer_d;
  logic             ped_pend_q, ped_pend_d;
  logic             ped_ack_q,  ped_ack_d;
`ifdef SEMAFORO_FLASH_EN
  logic             flash_q,    flash_d;
`endif

  logic             tick;
  logic             earlyExit;
  logic             phaseDone;
  logic             serve;
  logic [CNT_W-1:0] phaseLast;
  phase_e           phaseNext;

  assign tick = (presc_q == PRESC_LAST);

  always_comb begin
    phaseLast = ALLRED_LAST;
    phaseNext = NS_GREEN;
    unique case (phase_q)
      NS_GREEN:  begin phaseLast = GREEN_LAST;  phaseNext = NS_YELLOW; end
      NS_YELLOW: begin phaseLast = YELLOW_LAST; phaseNext = ALLRED_A;  end
      ALLRED_A:  begin phaseLast = ALLRED_LAST; phaseNext = EW_GREEN;  end
      EW_GREEN:  begin phaseLast = GREEN_LAST;  phaseNext = EW_YELLOW; end
      EW_YELLOW: begin phaseLast = YELLOW_LAST; phaseNext = ALLRED_B;  end
      ALLRED_B:  begin phaseLast = ALLRED_LAST; phaseNext = NS_GREEN;  end
      default:   begin phaseLast = ALLRED_LAST; phaseNext = NS_GREEN;  end
    endcase
  end

  // A pending request may end NS green on any tick once the minimum green
  // time has elapsed.
  assign earlyExit = (phase_q == NS_GREEN) && ped_pend_q && (timer_q >= MIN_LAST);
  assign phaseDone = (timer_q == phaseLast) || earlyExit;

  // Next-state logic. Under maintenance mode only the pedestrian latch keeps
  // moving. A request that arrives in the serve cycle is latched again, so it
  // is not lost.
  always_comb begin
    presc_d    = presc_q;
    timer_d    = timer_q;
    phase_d    = phase_q;
    ped_pend_d = ped_pend_q | ped_req;
    ped_ack_d  = 1'b0;
    serve      = 1'b0;
`ifdef SEMAFORO_FLASH_EN
    flash_d    = flash_q;
`endif
    if (maint) begin
      presc_d = presc_q;
`ifdef SEMAFORO_FLASH_EN
    end else if (night) begin
      presc_d    = tick ? '0 : presc_q + CNT_W'(1);
      timer_d    = '0;
      phase_d    = ALLRED_B;
      ped_pend_d = 1'b0;
      if (tick) flash_d = ~flash_q;
`endif
    end else begin
      presc_d = tick ? '0 : presc_q + CNT_W'(1);
      if (tick) begin
        if (phaseDone) begin
          phase_d = phaseNext;
          timer_d = '0;
          serve   = (phase_q == NS_GREEN);
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      ped_pend_d = (ped_pend_q & ~serve) | ped_req;
      ped_ack_d  = serve & ped_pend_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q    <= ALLRED_B;
      presc_q    <= '0;
      timer_q    <= '0;
      ped_pend_q <= 1'b0;
      ped_ack_q  <= 1'b0;
`ifdef SEMAFORO_FLASH_EN
      flash_q    <= 1'b0;
`endif
    end else begin
      phase_q    <= phase_d;
      presc_q    <= presc_d;
      timer_q    <= timer_d;
      ped_pend_q <= ped_pend_d;
      ped_ack_q  <= ped_ack_d;
`ifdef SEMAFORO_FLASH_EN
      flash_q    <= flash_d;
`endif
    end
  end

  // The lights are decoded directly from the registered phase, so they change
  // in the same cycle as the phase. Maintenance mode has top priority, and
  // two manual greens are never allowed to reach the outputs together.
  always_comb begin
    ns_lights = LIGHT_RED;
    ew_lights = LIGHT_RED;
    unique case (phase_q)
      NS_GREEN:  ns_lights = LIGHT_GREEN;
      NS_YELLOW: ns_lights = LIGHT_YELLOW;
      EW_GREEN:  ew_lights = LIGHT_GREEN;
      EW_YELLOW: ew_lights = LIGHT_YELLOW;
      default:   ns_lights = LIGHT_RED;
    endcase
    if (maint) begin
      if (man_ns[0] && man_ew[0]) begin
        ns_lights = LIGHT_RED;
        ew_lights = LIGHT_RED;
      end else begin
        ns_lights = man_ns;
        ew_lights = man_ew;
      end
`ifdef SEMAFORO_FLASH_EN
    end else if (night) begin
      ns_lights = {1'b0, flash_q, 1'b0};
      ew_lights = {1'b0, flash_q, 1'b0};
`endif
    end
  end

  assign phase   = phase_q;
  assign ped_ack = ped_ack_q;

endmodule
